// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command constants and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, WAIT_IDLE} ps2_state_e;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam int PS2_FRAME_EDGES = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes PS/2 clock/data pins and flags falling clock edges
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic sync_clk_o,
  output logic sync_dat_o,
  output logic clk_fall_o
);
  logic [STAGES-1:0] clk_q, dat_q;
  logic prev_q;
  // Reset to the idle-high bus level so leaving reset never looks like an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_q <= '1;
      dat_q <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q <= {clk_q[STAGES-2:0], ps2_clk_i};
      dat_q <= {dat_q[STAGES-2:0], ps2_dat_i};
      prev_q <= clk_q[STAGES-1];
    end
  end
  assign sync_clk_o = clk_q[STAGES-1];
  assign sync_dat_o = dat_q[STAGES-1];
  assign clk_fall_o = prev_q & ~clk_q[STAGES-1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter with open-drain line enables
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);
  localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  ps2_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;
  logic [9:0] frame_q, frame_d;
  logic dat_q, dat_d, err_q, err_d, done_q, done_d, tmo_q, tmo_d;
  logic sync_clk, sync_dat, clk_fall, last_edge, tmo_hit;
  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clock),
    .rst_i(reset),
    .ps2_clk_i(ps2_clk_in),
    .ps2_dat_i(ps2_dat_in),
    .sync_clk_o(sync_clk),
    .sync_dat_o(sync_dat),
    .clk_fall_o(clk_fall)
  );
  assign last_edge = clk_fall && edge_q == 4'(PS2_FRAME_EDGES - 1);
  assign tmo_hit = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      edge_q <= '0;
      frame_q <= '0;
      dat_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      edge_q <= edge_d;
      frame_q <= frame_d;
      dat_q <= dat_d;
      err_q <= err_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
    end
  end
  // frame_q shifts out data LSB first, then parity, then the stop bit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    edge_d = edge_q;
    frame_d = frame_q;
    dat_d = dat_q;
    err_d = err_q;
    done_d = 1'b0;
    tmo_d = 1'b0;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        cnt_d = '0;
        edge_d = '0;
        err_d = 1'b0;
        frame_d = {1'b1, odd_parity(tx_data), tx_data};
      end
      INHIBIT: begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
      end
      RTS: begin
        state_d = XFER;
        cnt_d = '0;
        edge_d = '0;
        dat_d = 1'b1;
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        if (last_edge) begin
          state_d = WAIT_IDLE;
          err_d = sync_dat;
          edge_d = edge_q + 4'd1;
          dat_d = 1'b0;
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_d = 1'b1;
          dat_d = 1'b0;
        end else if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          dat_d = ~frame_q[0];
          frame_d = {1'b0, frame_q[9:1]};
        end
      end
      WAIT_IDLE: begin
        cnt_d = cnt_q + CW'(1);
        if (sync_clk && sync_dat) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ps2_clk_oe = state_q == INHIBIT || state_q == RTS;
  assign ps2_dat_oe = state_q == RTS || (state_q == XFER && dat_q);
  assign tx_done = done_q;
  assign tx_ack_err = done_q & err_q;
  assign tx_timeout = tmo_q;
endmodule
